// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM states, frame geometry and baud-divider helper.
// Used by both the receiver and the transmitter on the same link.
package uart_pkg;

    localparam int FRAME_DATA_BITS = 8;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } uart_state_t;

    function automatic int baud_width(input int clock_speed, input int baud_rate);
        return clock_speed / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous input that idles high; N must be at least 2.
// Flops reset to 1 so a reset never looks like a start edge.
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '1;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames with an inverted payload, mid-bit sampling,
// and a valid/ready byte output with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
    localparam int HALF_WIDTH = BAUD_WIDTH / 2;
    localparam int CNT_W      = $clog2(BAUD_WIDTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);

    uart_state_t                state, state_next;
    logic [CNT_W-1:0]           cnt, cnt_next;
    logic [2:0]                 bit_idx, bit_idx_next;
    logic [FRAME_DATA_BITS-1:0] shift, shift_next;
    logic                       stop_sample;
    logic                       rx_s;

    uart_sync #(.N(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // START waits half a bit so every later sample lands on a bit midpoint.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        stop_sample  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BAUD_LAST) begin
                    shift_next[bit_idx] = rx_s;
                    cnt_next            = '0;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BAUD_LAST) begin
                    stop_sample = 1'b1;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A freshly completed byte takes priority over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_sample & ~rx_s;
            overrun   <= stop_sample & rx_s & rx_valid & ~rx_ready;
            if (stop_sample && rx_s) begin
                data     <= ~shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a randomized frame stream
// compared against a transaction-level model of accepted bytes, errors and overruns.
module tb_uart_rx;

    localparam int CLOCK_SPEED = 4_000_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int BW          = CLOCK_SPEED / BAUD_RATE;
    localparam int HALF        = BW / 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int vectors    = 0;
    int miscompares = 0;
    int err_cycles = 0;
    int ovr_cycles = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .BAUD_RATE   (BAUD_RATE),
        .CLOCK_SPEED (CLOCK_SPEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .data      (data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer side: record every accepted byte and every cycle a pulse is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(data);
            if (frame_err) err_cycles++;
            if (overrun) ovr_cycles++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame with inverted payload; cut_cycles > 0 stops part-way through.
    task automatic applyStimulus(input logic [7:0] payload, input logic stop_bit,
                                 input int cut_cycles);
        logic [9:0] frame;
        int total;
        frame = {stop_bit, ~payload, 1'b0};
        total = (cut_cycles > 0) ? cut_cycles : 10 * BW;
        for (int c = 0; c < total; c++) begin
            rx = frame[c / BW];
            @(posedge clk);
            #1;
        end
        if (cut_cycles == 0) rx = 1'b1;
    endtask

    task automatic clearStats();
        got.delete();
        exp_q.delete();
        err_cycles = 0;
        ovr_cycles = 0;
    endtask

    task automatic acceptOne();
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic       pend;
        logic [7:0] pend_byte;
        logic [7:0] payload;
        logic       r;
        logic       good;
        int         exp_err;
        int         exp_ovr;
        int         n;

        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        waitCycles(3);
        checkOutput("reset_data", data, 8'h00);
        checkOutput("reset_valid", rx_valid, 1'b0);
        checkOutput("reset_ferr", frame_err, 1'b0);
        checkOutput("reset_ovr", overrun, 1'b0);
        checkOutput("reset_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        waitCycles(3);

        $display("[TB] single frame 0xA5");
        clearStats();
        applyStimulus(8'hA5, 1'b1, 0);
        checkOutput("t1_data", data, 8'hA5);
        checkOutput("t1_valid", rx_valid, 1'b1);
        checkOutput("t1_ferr", err_cycles, 0);
        acceptOne();
        checkOutput("t1_valid_drop", rx_valid, 1'b0);
        checkOutput("t1_accepted", got.size(), 1);

        $display("[TB] back-to-back 0x00 0xFF 0x3C");
        clearStats();
        rx_ready = 1'b1;
        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, 0);
        applyStimulus(8'h3C, 1'b1, 0);
        waitCycles(5);
        rx_ready = 1'b0;
        checkOutput("t2_count", got.size(), 3);
        if (got.size() == 3) begin
            checkOutput("t2_b0", got[0], 8'h00);
            checkOutput("t2_b1", got[1], 8'hFF);
            checkOutput("t2_b2", got[2], 8'h3C);
        end
        checkOutput("t2_ferr", err_cycles, 0);
        checkOutput("t2_ovr", ovr_cycles, 0);

        $display("[TB] short low glitch");
        clearStats();
        rx = 1'b0;
        waitCycles(HALF / 4);
        checkOutput("t3_busy_mid", rx_busy, 1'b1);
        waitCycles(HALF / 2 - HALF / 4);
        rx = 1'b1;
        waitCycles(HALF + BW);
        checkOutput("t3_busy_end", rx_busy, 1'b0);
        checkOutput("t3_valid", rx_valid, 1'b0);
        checkOutput("t3_ferr", err_cycles, 0);

        $display("[TB] bad stop bit on 0x55");
        clearStats();
        applyStimulus(8'h55, 1'b0, 0);
        waitCycles(2 * BW);
        checkOutput("t4_ferr_cycles", err_cycles, 1);
        checkOutput("t4_valid", rx_valid, 1'b0);
        checkOutput("t4_ovr", ovr_cycles, 0);
        checkOutput("t4_busy", rx_busy, 1'b0);

        $display("[TB] overrun with consumer stalled");
        clearStats();
        applyStimulus(8'h12, 1'b1, 0);
        checkOutput("t5_first_data", data, 8'h12);
        checkOutput("t5_first_ovr", ovr_cycles, 0);
        applyStimulus(8'h9E, 1'b1, 0);
        checkOutput("t5_data", data, 8'h9E);
        checkOutput("t5_valid", rx_valid, 1'b1);
        checkOutput("t5_ovr_cycles", ovr_cycles, 1);
        acceptOne();
        checkOutput("t5_valid_drop", rx_valid, 1'b0);
        checkOutput("t5_accepted", got.size(), 1);
        if (got.size() == 1) checkOutput("t5_accepted_byte", got[0], 8'h9E);

        $display("[TB] reset mid-frame then 0x42");
        clearStats();
        applyStimulus(8'h81, 1'b1, 5 * BW + HALF);
        checkOutput("t6_busy_before", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_data", data, 8'h00);
        checkOutput("t6_rst_valid", rx_valid, 1'b0);
        checkOutput("t6_rst_busy", rx_busy, 1'b0);
        rx = 1'b1;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3);
        applyStimulus(8'h42, 1'b1, 0);
        checkOutput("t6_data", data, 8'h42);
        checkOutput("t6_valid", rx_valid, 1'b1);
        checkOutput("t6_ferr", err_cycles, 0);
        checkOutput("t6_ovr", ovr_cycles, 0);
        acceptOne();
        checkOutput("t6_accepted", got.size(), 1);

        $display("[TB] randomized frame stream");
        clearStats();
        pend    = 1'b0;
        pend_byte = 8'h00;
        exp_err = 0;
        exp_ovr = 0;
        for (int f = 0; f < 24; f++) begin
            r       = 1'($urandom_range(0, 1));
            payload = 8'($urandom);
            good    = ($urandom_range(0, 9) != 0);
            rx_ready = r;
            if (r && pend) begin
                exp_q.push_back(pend_byte);
                pend = 1'b0;
            end
            applyStimulus(payload, good, 0);
            if (good) begin
                if (r) begin
                    exp_q.push_back(payload);
                end else begin
                    if (pend) exp_ovr++;
                    pend      = 1'b1;
                    pend_byte = payload;
                end
            end else begin
                exp_err++;
            end
            // After a bad stop the line needs a full idle bit so the re-armed start is rejected.
            waitCycles(good ? $urandom_range(0, BW) : BW + $urandom_range(0, BW));
        end
        rx_ready = 1'b1;
        waitCycles(3);
        rx_ready = 1'b0;
        if (pend) exp_q.push_back(pend_byte);
        checkOutput("rand_count", got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("rand_byte%0d", i), got[i], exp_q[i]);
        end
        checkOutput("rand_ferr", err_cycles, exp_err);
        checkOutput("rand_ovr", ovr_cycles, exp_ovr);
        checkOutput("rand_valid_end", rx_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
